// File: rtl/chan_seq_pkg.sv
// rtl/chan_seq_pkg.sv - shared encodings for the one-hot channel sequencer
// Purpose: command mode and FSM state encodings, plus the dwell counter
// width helper, shared with the control FSMs that drive the sequencer.
// Ports: none (package).
package chan_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_ONCE = 2'b01,
    MODE_SCAN_LOOP = 2'b10,
    MODE_CLEAR     = 2'b11
  } cmd_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_SCAN = 2'b10
  } seq_state_e;

  // Counter must represent 0..dwell-1; sized as clog2(dwell+1) so that
  // dwell = 1 still yields a 1-bit counter.
  function automatic int dwell_cnt_width(input int dwell);
    return $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/onehot_channel_sequencer_if.sv
// rtl/onehot_channel_sequencer_if.sv - command handshake bundle for the sequencer
// Purpose: groups the valid/ready command channel.
// Signals:
//   cmd_valid  command present (master -> slave)
//   cmd_ready  command accepted on valid && ready (slave -> master)
//   cmd_mode   2-bit mode, see chan_seq_pkg::cmd_mode_e
//   cmd_sel    channel index (target or scan start)
interface onehot_channel_sequencer_if #(
  parameter int SEL_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [SEL_W-1:0] cmd_sel;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_sel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_sel,
    output cmd_ready
  );
endinterface

// File: rtl/onehot_decode.sv
// rtl/onehot_decode.sv - combinational index to one-hot decoder
// Purpose: converts a binary index into a one-hot vector; an index at or
// beyond N_CH produces all zeros, which the parent uses as its range check.
// Ports:
//   idx_i     binary channel index
//   onehot_o  one-hot vector, zero when idx_i >= N_CH
module onehot_decode #(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] idx_i,
  output logic [N_CH-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(idx_i) == i) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_channel_sequencer.sv
// rtl/onehot_channel_sequencer.sv - registered one-hot channel enable with scan engine
// Purpose: holds a registered one-hot channel enable selected by command, or
// sweeps channels autonomously (single pass or looping) with a programmable
// dwell per channel.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   cmd         command handshake (slave side)
//   stall       freezes the scan position and dwell counter
//   abort       returns to IDLE with all outputs cleared
//   y           one-hot channel enable, zero when inactive
//   y_idx       binary index of the active channel
//   y_valid     y holds exactly one set bit
//   busy        scan in progress
//   scan_done   one-cycle pulse at scan completion or wrap
//   sel_err     one-cycle pulse when a command index is out of range
module onehot_channel_sequencer
  import chan_seq_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  onehot_channel_sequencer_if.slave cmd,
  input  logic                      stall,
  input  logic                      abort,
  output logic [N_CH-1:0]           y,
  output logic [SEL_W-1:0]          y_idx,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      sel_err
);

  localparam int DW = dwell_cnt_width(DWELL);

  seq_state_e       state_q, state_d;
  logic [N_CH-1:0]  y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [N_CH-1:0]  cmd_onehot;
  logic             cmd_ready;
  logic             accept;
  logic             dwell_end;
  logic             last_ch;
  cmd_mode_e        mode;

  onehot_decode #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_decode (
    .idx_i    (cmd.cmd_sel),
    .onehot_o (cmd_onehot)
  );

  // Reset low is treated like abort so nothing is accepted while held.
  assign cmd_ready     = (state_q != ST_SCAN) && !abort && rst_n;
  assign cmd.cmd_ready = cmd_ready;
  assign accept        = cmd.cmd_valid && cmd_ready;
  assign mode          = cmd_mode_e'(cmd.cmd_mode);
  assign dwell_end     = (int'(dwell_q) == DWELL - 1);
  assign last_ch       = (int'(idx_q) == N_CH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      dwell_q <= dwell_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      y_d     = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      dwell_d = '0;
      loop_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_SCAN: begin
          if (!stall) begin
            if (dwell_end) begin
              dwell_d = '0;
              if (last_ch) begin
                done_d = 1'b1;
                if (loop_q) begin
                  y_d   = {{(N_CH-1){1'b0}}, 1'b1};
                  idx_d = '0;
                end else begin
                  state_d = ST_IDLE;
                  y_d     = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  loop_d  = 1'b0;
                end
              end else begin
                // Shifting the one-hot keeps y and y_idx in lockstep.
                y_d   = y_q << 1;
                idx_d = idx_q + 1'b1;
              end
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end

        default: begin
          if (accept) begin
            if (mode == MODE_CLEAR) begin
              state_d = ST_IDLE;
              y_d     = '0;
              idx_d   = '0;
              valid_d = 1'b0;
            end else if (cmd_onehot == '0) begin
              // Out-of-range index: drop command, keep current output.
              err_d = 1'b1;
            end else begin
              y_d     = cmd_onehot;
              idx_d   = cmd.cmd_sel;
              valid_d = 1'b1;
              dwell_d = '0;
              if (mode == MODE_DIRECT) begin
                state_d = ST_HOLD;
                loop_d  = 1'b0;
              end else begin
                state_d = ST_SCAN;
                loop_d  = (mode == MODE_SCAN_LOOP);
              end
            end
          end
        end
      endcase
    end
  end

  assign y         = y_q;
  assign y_idx     = idx_q;
  assign y_valid   = valid_q;
  assign busy      = (state_q == ST_SCAN);
  assign scan_done = done_q;
  assign sel_err   = err_q;

endmodule
